// File: rtl/stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stream_pkg                                                                  |
// | Shared types and default geometry for the lane converter/framer pair.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package stream_pkg;

    localparam int DEF_DATA_WIDTH     = 64;
    localparam int LANE_WIDTH         = DEF_DATA_WIDTH / 2;
    localparam int DEF_ACTIVE_SAMPLES = 3276;
    localparam int DEF_IDLE_CYCLES    = 1172;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

endpackage : stream_pkg
`default_nettype wire

// File: rtl/lane_burst_framer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lane_burst_framer_if                                                        |
// | Dual-lane input and packed ready/valid output of the burst framer.          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface lane_burst_framer_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH/2-1:0] data_port1;
    logic                    valid1;
    logic [DATA_WIDTH/2-1:0] data_port2;
    logic                    valid2;
    logic [DATA_WIDTH-1:0]   m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_last;

    // master: upstream lane source plus downstream sink; slave: the framer
    modport master (
        output data_port1, valid1, data_port2, valid2, m_ready,
        input  m_data, m_valid, m_last
    );

    modport slave (
        input  data_port1, valid1, data_port2, valid2, m_ready,
        output m_data, m_valid, m_last
    );
endinterface : lane_burst_framer_if
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo                                                                   |
// | Fall-through synchronous FIFO; a write when full is taken only with a read. |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 1024
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_wr_en,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic             i_rd_en,
    output logic      [WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign w_rd_ok = i_rd_en && !o_empty;
    assign w_wr_ok = i_wr_en && (!o_full || w_rd_ok);

    // Head is zeroed while empty so the output bus idles at a known value
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/lane_burst_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lane_burst_framer                                                           |
// | Packs aligned lane pairs into framed 64-bit beats with burst/gap checking.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module lane_burst_framer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ACTIVE_SAMPLES = DEF_ACTIVE_SAMPLES,
    parameter int IDLE_CYCLES    = DEF_IDLE_CYCLES,
    parameter int MIN_GAP        = 16,
    parameter int TIMEOUT        = 64,
    parameter int FIFO_DEPTH     = 1024
) (
    input  wire logic        clk,
    input  wire logic        reset,
    lane_burst_framer_if.slave bus,
    input  wire logic        err_clr,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      drop_cnt,
    output logic             err_skew,
    output logic             err_short,
    output logic             err_gap,
    output logic             err_ovf
);
    localparam int BC_W = (ACTIVE_SAMPLES > 1) ? $clog2(ACTIVE_SAMPLES) : 1;
    localparam int GC_W = $clog2(MIN_GAP + 1);
    localparam int IR_W = $clog2(TIMEOUT + 1);

    localparam logic [BC_W-1:0] C_LAST_IDX   = BC_W'(ACTIVE_SAMPLES - 1);
    localparam logic [GC_W-1:0] C_MIN_GAP    = GC_W'(MIN_GAP);
    localparam logic [IR_W-1:0] C_IDLE_LIMIT = IR_W'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BC_W-1:0] r_beat_cnt;
    logic [BC_W-1:0] w_beat_nxt;
    logic [GC_W-1:0] r_gap_cnt;
    logic [GC_W-1:0] w_gap_nxt;
    logic [IR_W-1:0] r_idle_run;
    logic [IR_W-1:0] w_idle_nxt;
    logic [15:0]     r_frame_cnt;
    logic [15:0]     r_drop_cnt;
    logic            r_err_skew;
    logic            r_err_short;
    logic            r_err_gap;
    logic            r_err_ovf;

    logic            w_beat;
    logic            w_skew;
    logic            w_wr_en;
    logic            w_wr_last;
    logic            w_frame_inc;
    logic            w_set_short;
    logic            w_set_gap;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_drop;
    logic [DATA_WIDTH:0] w_fifo_rd;

    assign w_beat = bus.valid1 && bus.valid2;
    assign w_skew = bus.valid1 ^ bus.valid2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= WAIT;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
            r_idle_run <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_idle_run <= w_idle_nxt;
        end
    end

    // A skewed cycle is simply not a beat, so it falls into the no-valid paths
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_idle_nxt  = r_idle_run;
        w_wr_en     = 1'b0;
        w_wr_last   = 1'b0;
        w_frame_inc = 1'b0;
        w_set_short = 1'b0;
        w_set_gap   = 1'b0;
        case (r_state)
            WAIT: begin
                if (w_beat) begin
                    w_wr_en     = 1'b1;
                    w_beat_nxt  = BC_W'(1);
                    w_idle_nxt  = '0;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_beat) begin
                    w_wr_en    = 1'b1;
                    w_idle_nxt = '0;
                    if (r_beat_cnt == C_LAST_IDX) begin
                        w_wr_last   = 1'b1;
                        w_frame_inc = 1'b1;
                        w_beat_nxt  = '0;
                        w_gap_nxt   = '0;
                        w_state_nxt = GAP;
                    end else begin
                        w_beat_nxt = r_beat_cnt + BC_W'(1);
                    end
                end else if (r_idle_run == C_IDLE_LIMIT) begin
                    w_set_short = 1'b1;
                    w_beat_nxt  = '0;
                    w_idle_nxt  = '0;
                    w_state_nxt = WAIT;
                end else begin
                    w_idle_nxt = r_idle_run + IR_W'(1);
                end
            end
            GAP: begin
                if (w_beat) begin
                    w_set_gap   = (r_gap_cnt < C_MIN_GAP);
                    w_wr_en     = 1'b1;
                    w_beat_nxt  = BC_W'(1);
                    w_idle_nxt  = '0;
                    w_state_nxt = ACTIVE;
                end else if (r_gap_cnt < C_MIN_GAP) begin
                    w_gap_nxt = r_gap_cnt + GC_W'(1);
                end
            end
            default: begin
                w_state_nxt = WAIT;
            end
        endcase
    end

    assign w_pop  = !w_empty && bus.m_ready;
    assign w_drop = w_wr_en && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data ({w_wr_last, bus.data_port2, bus.data_port1}),
        .i_rd_en   (bus.m_ready),
        .o_rd_data (w_fifo_rd),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign bus.m_valid = !w_empty;
    assign bus.m_data  = w_fifo_rd[DATA_WIDTH-1:0];
    assign bus.m_last  = w_fifo_rd[DATA_WIDTH];

    // A new error in the same cycle as err_clr keeps its flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
            r_err_skew  <= 1'b0;
            r_err_short <= 1'b0;
            r_err_gap   <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
            r_err_skew  <= w_skew      | (r_err_skew  & ~err_clr);
            r_err_short <= w_set_short | (r_err_short & ~err_clr);
            r_err_gap   <= w_set_gap   | (r_err_gap   & ~err_clr);
            r_err_ovf   <= w_drop      | (r_err_ovf   & ~err_clr);
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign err_skew  = r_err_skew;
    assign err_short = r_err_short;
    assign err_gap   = r_err_gap;
    assign err_ovf   = r_err_ovf;

endmodule : lane_burst_framer
`default_nettype wire

// File: tb/tb_lane_burst_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lane_burst_framer                                                        |
// | Directed bench: 8-beat bursts, MIN_GAP 4, TIMEOUT 5, 4-entry FIFO.          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_lane_burst_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        err_clr = 1'b0;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        err_skew;
    logic        err_short;
    logic        err_gap;
    logic        err_ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [64:0] exp_q[$];
    logic [64:0] got_q[$];

    lane_burst_framer_if #(.DATA_WIDTH(64)) bus ();

    lane_burst_framer #(
        .DATA_WIDTH     (64),
        .ACTIVE_SAMPLES (8),
        .IDLE_CYCLES    (6),
        .MIN_GAP        (4),
        .TIMEOUT        (5),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .err_clr   (err_clr),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .err_skew  (err_skew),
        .err_short (err_short),
        .err_gap   (err_gap),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && bus.m_valid && bus.m_ready)
            got_q.push_back({bus.m_last, bus.m_data});
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v1, input logic v2, input logic [31:0] d1, input logic [31:0] d2);
        @(negedge clk);
        bus.valid1     = v1;
        bus.valid2     = v2;
        bus.data_port1 = d1;
        bus.data_port2 = d2;
    endtask

    task automatic send(input logic [31:0] d1, input logic [31:0] d2, input bit keep, input bit last);
        drive(1'b1, 1'b1, d1, d2);
        if (keep) exp_q.push_back({last, d2, d1});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.valid1 = 1'b0;
        bus.valid2 = 1'b0;
        err_clr    = 1'b1;
        @(negedge clk);
        err_clr    = 1'b0;
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 65'(got_q.size()), 65'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp);
        check(tag, 65'({err_skew, err_short, err_gap, err_ovf}), 65'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid1     = 1'b0;
        bus.valid2     = 1'b0;
        bus.data_port1 = '0;
        bus.data_port2 = '0;
        bus.m_ready    = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", 65'(bus.m_valid), 65'd0);
        check("rst_m_last",  65'(bus.m_last),  65'd0);
        check("rst_m_data",  65'(bus.m_data),  65'd0);
        check("rst_frame",   65'(frame_cnt),   65'd0);
        check("rst_drop",    65'(drop_cnt),    65'd0);
        check_flags("rst_flags", 4'b0000);
        reset = 1'b0;

        // 1: two clean bursts separated by a legal gap
        for (int i = 0; i < 8; i++) send(32'(i), 32'(i + 'h100), 1'b1, i == 7);
        idle(6);
        for (int i = 8; i < 16; i++) send(32'(i), 32'(i + 'h100), 1'b1, i == 15);
        idle(6);
        check_stream("t1_out");
        check("t1_frame", 65'(frame_cnt), 65'd2);
        check_flags("t1_flags", 4'b0000);

        // 2: one skewed cycle mid-burst
        for (int i = 0; i < 4; i++) send(32'('h200 + i), 32'('hA200 + i), 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'hDEAD, 32'hBEEF);
        for (int i = 4; i < 8; i++) send(32'('h200 + i), 32'('hA200 + i), 1'b1, i == 7);
        idle(6);
        check_stream("t2_out");
        check_flags("t2_flags_set", 4'b1000);
        check("t2_frame", 65'(frame_cnt), 65'd3);
        pulse_clr();
        check_flags("t2_flags_clr", 4'b0000);
        idle(6);

        // 3: timeout aborts a 3-beat burst; then a full burst from WAIT
        for (int i = 0; i < 3; i++) send(32'('h300 + i), 32'('hA300 + i), 1'b1, 1'b0);
        idle(6);
        check_flags("t3_short", 4'b0100);
        check("t3_frame", 65'(frame_cnt), 65'd3);
        check_stream("t3_abort_out");
        for (int i = 0; i < 8; i++) send(32'('h310 + i), 32'('hA310 + i), 1'b1, i == 7);

        // 4: gap of only 2 cycles; the next beat is beat 1 of a new burst
        idle(2);
        check_flags("t4_pre_gap", 4'b0100);
        for (int i = 0; i < 8; i++) send(32'('h400 + i), 32'('hA400 + i), 1'b1, i == 7);
        idle(6);
        check_stream("t34_out");
        check_flags("t4_gap", 4'b0110);
        check("t4_frame", 65'(frame_cnt), 65'd5);
        pulse_clr();
        check_flags("t4_clr", 4'b0000);
        idle(6);

        // 5: overflow with m_ready low, then a write accepted while full with a pop
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(32'('h500 + i), 32'('hA500 + i), i < 4, 1'b0);
        idle(1);
        check("t5_drop", 65'(drop_cnt), 65'd2);
        check_flags("t5_ovf", 4'b0001);
        check("t5_head", 65'({bus.m_valid, bus.m_data}), {1'b1, 32'hA500, 32'h500});
        @(negedge clk);
        bus.m_ready    = 1'b1;
        bus.valid1     = 1'b1;
        bus.valid2     = 1'b1;
        bus.data_port1 = 32'h506;
        bus.data_port2 = 32'hA506;
        exp_q.push_back({1'b0, 32'hA506, 32'h506});
        send(32'h507, 32'hA507, 1'b1, 1'b1);
        idle(6);
        check("t5_drop_hold", 65'(drop_cnt), 65'd2);
        check("t5_frame", 65'(frame_cnt), 65'd6);
        check_stream("t5_out");
        idle(6);

        // 6: reset mid-burst with 3 entries buffered
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'('h600 + i), 32'('hA600 + i), 1'b0, 1'b0);
        idle(1);
        check("t6_pre_valid", 65'(bus.m_valid), 65'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_m_valid", 65'(bus.m_valid), 65'd0);
        check("t6_frame",   65'(frame_cnt),   65'd0);
        check("t6_drop",    65'(drop_cnt),    65'd0);
        check_flags("t6_flags", 4'b0000);
        got_q.delete();
        exp_q.delete();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(32'('h610 + i), 32'('hA610 + i), 1'b1, i == 7);
        idle(6);
        check_stream("t6_out");
        check("t6_frame_after", 65'(frame_cnt), 65'd1);
        check_flags("t6_flags_after", 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_lane_burst_framer
`default_nettype wire

// File: doc/lane_burst_framer.md
Name: lane_burst_framer

Overview:
- Directly downstream of the 64-bit-to-dual-32-bit stream converter.
- Accepts the two 32-bit lanes (data_port1/valid1, data_port2/valid2). The lanes carry no backpressure. Input arrives in bursts of ACTIVE_SAMPLES beats, separated by idle gaps of about IDLE_CYCLES.
- Re-packs each aligned lane pair into one 64-bit beat, buffers it, and emits a ready/valid stream with m_last on the final beat of each burst.
- Checks lane alignment, burst length and gap length. Results are reported as sticky error flags and counters.

Parameters:
- DATA_WIDTH, 64, packed output width; each lane is DATA_WIDTH/2 bits.
- ACTIVE_SAMPLES, 3276, beats per complete burst.
- IDLE_CYCLES, 1172, nominal gap length between bursts.
- MIN_GAP, 16, minimum legal gap in cycles; a shorter gap is an error.
- TIMEOUT, 64, number of consecutive no-valid cycles inside a burst that aborts it.
- FIFO_DEPTH, 1024, output buffer depth in entries; must be a power of 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- data_port1  in  DATA_WIDTH/2  lane 1 data (low half).
- valid1  in  1  lane 1 valid.
- data_port2  in  DATA_WIDTH/2  lane 2 data (high half).
- valid2  in  1  lane 2 valid.
- m_data  out  DATA_WIDTH  packed beat {lane2, lane1}.
- m_valid  out  1  output beat available.
- m_ready  in  1  downstream accept.
- m_last  out  1  final beat of a complete burst.
- frame_cnt  out  16  count of completed bursts; wraps.
- drop_cnt  out  16  count of beats dropped on overflow; saturates at 0xFFFF.
- err_skew  out  1  sticky: valid1 != valid2 was seen.
- err_short  out  1  sticky: a burst was aborted by TIMEOUT.
- err_gap  out  1  sticky: a gap shorter than MIN_GAP was seen.
- err_ovf  out  1  sticky: FIFO overflow occurred.
- err_clr  in  1  clears all sticky error flags (counters are not cleared).

Behaviour:
- Reset is synchronous and active-high. While reset is sampled high: FIFO empty, FSM in WAIT, all counters 0, all flags 0. Consequently m_valid=0, m_last=0, m_data=0 (when the FIFO is empty). Asserting reset mid-burst discards buffered data immediately.
- Beat definition: a beat is a cycle with valid1 && valid2. The beat is {data_port2, data_port1} plus a last bit.
- Skew: a cycle with valid1 XOR valid2 sets err_skew. That cycle is not written and not counted, and it counts as a no-valid cycle.
- FSM states: WAIT, ACTIVE, GAP. The state enum lives in the package.
  - WAIT: no beats in progress. A beat writes with last=0, sets beat_cnt=1 and moves to ACTIVE.
  - ACTIVE, on a beat: beat_cnt increments. If beat_cnt == ACTIVE_SAMPLES-1 before the increment, the beat is written with last=1, frame_cnt increments, beat_cnt clears, gap_cnt clears and the FSM moves to GAP.
  - ACTIVE, on a no-valid cycle: idle_run increments. When idle_run reaches TIMEOUT, err_short is set, beat_cnt clears and the FSM moves to WAIT. The beats already written keep last=0, and no last is fabricated. idle_run clears on every beat.
  - GAP: gap_cnt increments on no-valid cycles, saturating. A beat arriving with gap_cnt < MIN_GAP sets err_gap. Any beat in GAP is treated as the first beat of a new burst: write with last=0, set beat_cnt=1 and move to ACTIVE.
- FIFO: entry width is DATA_WIDTH+1. Write latency is 1 cycle: a beat at cycle N gives m_valid=1 at N+1 if the FIFO was empty. m_data/m_last are fall-through from the head.
  - m_valid is !empty.
  - A pop occurs on m_valid && m_ready.
- Full boundary: if the FIFO is full and a pop occurs in the same cycle, the incoming write is accepted. If full with no pop, the beat is dropped, err_ovf is set and drop_cnt increments. A dropped beat is still counted by the FSM, so burst framing is preserved. If the dropped beat carried last, the framing is lost: frame_cnt still increments and m_last for that burst never appears.
- Pointers are $clog2(FIFO_DEPTH) bits plus 1 wrap bit. Full/empty are decided by comparing the wrap bits.
- beat_cnt width is $clog2(ACTIVE_SAMPLES); gap_cnt and idle_run are sized to hold MIN_GAP and TIMEOUT respectively.
- err_clr: clears all flags in the next cycle. If err_clr and a new error event occur in the same cycle, the set wins.

Decomposition:
- Package stream_pkg holds:
  - state_t (WAIT, ACTIVE, GAP);
  - localparam LANE_WIDTH = DATA_WIDTH/2;
  - the default ACTIVE_SAMPLES and IDLE_CYCLES values, shared with the converter.
- One sub-module: sync_fifo, parameterised by WIDTH and DEPTH.
  - Fall-through read, simultaneous read and write, and write-when-full allowed only with a concurrent read.
  - Outputs full and empty.

Test Plan:
1. Use ACTIVE_SAMPLES=8, MIN_GAP=4, m_ready=1. Drive 8 beats {i+0x100, i}, then a 6-cycle gap, then 8 beats -> 16 outputs in order, m_last on outputs 7 and 15, frame_cnt=2, all error flags 0.
2. Set valid1=1, valid2=0 for one cycle in the middle of a burst -> err_skew=1, that cycle emits nothing, the burst still ends after 8 good beats with m_last, and err_clr clears the flag next cycle.
3. Use TIMEOUT=5. Send 3 beats, then 5 idle cycles -> err_short=1, 3 outputs all with last=0, frame_cnt unchanged, and the next beat starts a new burst of 8.
4. After a complete burst, send the next beat after a 2-cycle gap -> err_gap=1, and that beat is counted as beat 1 of a new burst.
5. Use FIFO_DEPTH=4 with m_ready=0 and drive 6 beats -> 4 buffered, drop_cnt=2, err_ovf=1. Then, while full, assert m_ready=1 and send a beat in the same cycle -> it is accepted and drop_cnt stays 2.
6. Assert reset mid-burst with 3 entries buffered -> m_valid=0 the next cycle, counters and flags are 0, and the next beat after reset starts a new burst in WAIT→ACTIVE.
